// File: rtl/cmd_arb_pkg.sv
// Shared definitions for the command arbiter.
//   - FSM state encodings for the latch sequencer
//   - Command field positions used to recognise a "run start" command
//   - is_run_start(): helper that decodes the run-start condition
package cmd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

  // Command section field [31:30] and the run-start flag in bit 29
  localparam logic [1:0] CMD_SECTION_RUN   = 2'b11;
  localparam int         CMD_SECTION_HI    = 31;
  localparam int         CMD_SECTION_LO    = 30;
  localparam int         CMD_RUN_START_BIT = 29;

  function automatic logic is_run_start(input logic [31:0] cmd);
    return (cmd[CMD_SECTION_HI:CMD_SECTION_LO] == CMD_SECTION_RUN) &&
           cmd[CMD_RUN_START_BIT];
  endfunction

endpackage

// File: rtl/cmd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin one-hot picker.
// Ports:
//   req   in  NUM_REQ : request vector
//   ptr   in  2       : index of the previous winner; search starts at ptr+1
//   mask  in  NUM_REQ : requests allowed to win (all ones when unrestricted)
//   grant out NUM_REQ : one-hot grant, zero when no masked request is set
module rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    logic [NUM_REQ-1:0] req_m;
    logic               found;
    int                 idx;
    req_m = req & mask;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    // Visit candidates in order ptr+1, ptr+2, ... wrapping at NUM_REQ;
    // the first masked request seen wins.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && (j == idx) && req_m[j]) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cmd_arbiter.sv
// cmd_arbiter: shares the 32-bit controller command port between NUM_REQ
// sources. One command is accepted at a time in round-robin order, driven on
// cmd_data, then strobed with a single clean latch_data pulse framed by a
// one-cycle setup and a GAP_CYCLES recovery gap.
//
// Optional feature: define CMD_ARB_RUN_LOCK_EN to enable the run-lock. A run
// start command (section 2'b11, bit 29 set) locks the arbiter to its sender
// until that sender issues any other command. Without the macro the arbiter
// is pure round-robin and lock_active is tied low.
//
// Ports:
//   clock       in  1           system clock, rising edge
//   reset_n     in  1           asynchronous active-low reset
//   req_valid   in  NUM_REQ     requester i offers a command
//   req_data    in  32*NUM_REQ  command of requester i in [32i+31:32i]
//   req_ready   out NUM_REQ     one-hot accept (IDLE only)
//   cmd_data    out 32          registered command to the controller
//   latch_data  out 1           registered latch strobe
//   grant_id    out 2           index of the last accepted requester
//   busy        out 1           high in any state other than IDLE
//   lock_active out 1           run-lock held
module cmd_arbiter
  import cmd_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           cmd_data,
  output logic                  latch_data,
  output logic [1:0]            grant_id,
  output logic                  busy,
  output logic                  lock_active
);

  localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [1:0]       PTR_RST    = 2'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        cmd_q, cmd_d;
  logic               latch_q, latch_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         ptr_q, ptr_d;

  logic [NUM_REQ-1:0] lock_mask;
  logic [NUM_REQ-1:0] pick;
  logic [1:0]         win_idx;
  logic [31:0]        win_cmd;
  logic               transfer;

`ifdef CMD_ARB_RUN_LOCK_EN
  logic       lock_q, lock_d;
  logic [1:0] owner_q, owner_d;

  // While locked only the owner may be picked.
  always_comb begin
    lock_mask = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      lock_mask[j] = !lock_q || (2'(j) == owner_q);
    end
  end

  assign lock_active = lock_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_q  <= 1'b0;
      owner_q <= 2'd0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end
`else
  assign lock_mask   = '1;
  assign lock_active = 1'b0;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .mask  (lock_mask),
    .grant (pick)
  );

  // Offer the picked requester only while idle; held low during reset so
  // nothing appears accepted while the flops are cleared.
  always_comb begin
    req_ready = '0;
    if ((state_q == ST_IDLE) && reset_n) req_ready = pick;
  end

  assign transfer = |(req_valid & req_ready);

  // Decode the one-hot pick into an index and select its command word.
  always_comb begin
    win_idx = 2'd0;
    win_cmd = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (pick[j]) begin
        win_idx = 2'(j);
        win_cmd = req_data[j*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    latch_d = latch_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
`ifdef CMD_ARB_RUN_LOCK_EN
    lock_d  = lock_q;
    owner_d = owner_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          cmd_d   = win_cmd;
          grant_d = win_idx;
          ptr_d   = win_idx;
          state_d = ST_SETUP;
`ifdef CMD_ARB_RUN_LOCK_EN
          if (is_run_start(win_cmd)) begin
            lock_d  = 1'b1;
            owner_d = win_idx;
          end else if (lock_q && (owner_q == win_idx)) begin
            lock_d  = 1'b0;
          end
`endif
        end
      end
      ST_SETUP: begin
        // cmd_data has been stable one cycle; raise the strobe.
        state_d = ST_PULSE;
        latch_d = 1'b1;
        cnt_d   = PULSE_LOAD;
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          latch_d = 1'b0;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        latch_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      latch_q <= 1'b0;
      grant_q <= 2'd0;
      ptr_q   <= PTR_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      latch_q <= latch_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign cmd_data   = cmd_q;
  assign latch_data = latch_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cmd_arbiter.sv
// Testbench for cmd_arbiter: reset values, a single-command timing profile,
// a table of grant vectors, back-to-back, reset mid-pulse, the run-lock
// sequence (either build) and a randomized run against a transaction model.
module tb_cmd_arbiter;

  localparam int NR       = 2;
  localparam int P        = 2;
  localparam int G        = 2;
  localparam int BUSY_LEN = 1 + P + G;
`ifdef CMD_ARB_RUN_LOCK_EN
  localparam logic LOCK_EN = 1'b1;
`else
  localparam logic LOCK_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [31:0]       dat [NR];
  logic [32*NR-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic [31:0]       cmd_data;
  logic              latch_data;
  logic [1:0]        grant_id;
  logic              busy;
  logic              lock_active;

  assign req_data = {dat[1], dat[0]};

  always #5 clock = ~clock;

  cmd_arbiter #(
    .NUM_REQ      (NR),
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .cmd_data    (cmd_data),
    .latch_data  (latch_data),
    .grant_id    (grant_id),
    .busy        (busy),
    .lock_active (lock_active)
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level model: age counts cycles since the accepting edge.
  int          m_ptr, m_age, m_grant, m_owner;
  logic        m_lock;
  logic [31:0] m_cmd;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  exp_ready;
    logic [31:0] exp_cmd;
    logic [1:0]  exp_grant;
    logic        exp_busy;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    dat[0]    = '0;
    dat[1]    = '0;
    repeat (2) @(posedge clock);
    #3;
    reset_n = 1'b1;
    step();
    m_ptr = NR - 1; m_age = BUSY_LEN; m_cmd = '0; m_grant = 0;
    m_lock = 1'b0; m_owner = 0;
  endtask

  function automatic int model_pick(input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (m_ptr + k) % NR;
      if (v[i] && (!m_lock || i == m_owner)) return i;
    end
    return -1;
  endfunction

  initial begin
    tbl[0] = '{2'b01, 32'h0001_00AA, 32'h0,         2'b01, 32'h0001_00AA, 2'd0, 1'b1};
    tbl[1] = '{2'b11, 32'h1111_1111, 32'h2222_2222, 2'b10, 32'h2222_2222, 2'd1, 1'b1};
    tbl[2] = '{2'b11, 32'h3333_3333, 32'h4444_4444, 2'b01, 32'h3333_3333, 2'd0, 1'b1};
    tbl[3] = '{2'b01, 32'h5555_5555, 32'h0,         2'b01, 32'h5555_5555, 2'd0, 1'b1};
    tbl[4] = '{2'b10, 32'h0,         32'h6666_6666, 2'b10, 32'h6666_6666, 2'd1, 1'b1};
    tbl[5] = '{2'b10, 32'h0,         32'h7777_7777, 2'b10, 32'h7777_7777, 2'd1, 1'b1};
    tbl[6] = '{2'b00, 32'h0,         32'h0,         2'b00, 32'h7777_7777, 2'd1, 1'b0};

    // Reset values, with both requesters asking during reset
    reset_n   = 1'b0;
    req_valid = 2'b11;
    dat[0]    = 32'hDEAD_0000;
    dat[1]    = 32'hDEAD_0001;
    #12;
    chk("rst_cmd",   cmd_data,    32'h0);
    chk("rst_latch", latch_data,  1'b0);
    chk("rst_grant", grant_id,    2'd0);
    chk("rst_busy",  busy,        1'b0);
    chk("rst_lock",  lock_active, 1'b0);
    chk("rst_ready", req_ready,   2'b00);

    // Single request timing profile
    do_reset();
    req_valid = 2'b01;
    dat[0]    = 32'h0001_00AA;
    #1;
    chk("single_ready", req_ready, 2'b01);
    step();
    req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      chk("single_cmd",   cmd_data,   32'h0001_00AA);
      chk("single_latch", latch_data, (k >= 1 && k <= P));
      chk("single_busy",  busy,       (k < BUSY_LEN));
      step();
    end

    // Table of grants from a fresh reset (pointer sequence matters)
    do_reset();
    for (int t = 0; t < 7; t++) begin
      req_valid = tbl[t].valid;
      dat[0]    = tbl[t].d0;
      dat[1]    = tbl[t].d1;
      #1;
      chk("tbl_ready", req_ready, tbl[t].exp_ready);
      step();
      req_valid = '0;
      chk("tbl_cmd",   cmd_data, tbl[t].exp_cmd);
      chk("tbl_grant", grant_id, tbl[t].exp_grant);
      chk("tbl_busy",  busy,     tbl[t].exp_busy);
      if (tbl[t].exp_busy) repeat (BUSY_LEN) step();
    end

    // Back-to-back: req 1 holds valid across three commands
    begin
      int          accepted, low_run, pulses;
      logic        prev_latch, prev_busy;
      logic [31:0] prev_cmd;
      do_reset();
      dat[1]    = 32'h0B0B_0001;
      req_valid = 2'b10;
      accepted = 0; low_run = 0; pulses = 0;
      prev_latch = 1'b0; prev_busy = 1'b0; prev_cmd = cmd_data;
      for (int c = 0; c < 40; c++) begin
        logic acc;
        if (latch_data && !prev_latch) begin
          pulses++;
          chk("b2b_low_before_pulse", 32'(low_run >= 2), 32'd1);
          low_run = 0;
        end else if (!latch_data) begin
          low_run++;
        end
        if (cmd_data !== prev_cmd)
          chk("b2b_cmd_only_in_setup", 32'(busy && !prev_busy), 32'd1);
        prev_latch = latch_data; prev_busy = busy; prev_cmd = cmd_data;
        #1;
        acc = req_ready[1] && req_valid[1];
        step();
        if (acc) begin
          accepted++;
          if (accepted < 3) dat[1] = dat[1] + 32'd1;
          else req_valid = '0;
        end
      end
      chk("b2b_pulses", pulses, 3);
      chk("b2b_last_cmd", cmd_data, 32'h0B0B_0003);
    end

    // Reset during PULSE
    do_reset();
    req_valid = 2'b11;
    dat[0]    = 32'h1234_5678;
    dat[1]    = 32'h0000_BEEF;
    #1;
    chk("mid_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b10;
    step();
    chk("mid_in_pulse", latch_data, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_latch", latch_data, 1'b0);
    chk("mid_rst_cmd",   cmd_data,   32'h0);
    chk("mid_rst_busy",  busy,       1'b0);
    chk("mid_rst_ready", req_ready,  2'b00);
    @(negedge clock);
    reset_n   = 1'b1;
    dat[0]    = 32'h1234_5679;
    req_valid = 2'b11;
    #1;
    chk("mid_prio_ready", req_ready, 2'b01);
    step();
    req_valid = '0;
    chk("mid_prio_grant", grant_id, 2'd0);
    chk("mid_prio_cmd",   cmd_data, 32'h1234_5679);
    repeat (BUSY_LEN) step();

    // Run-lock sequence
    do_reset();
    dat[0]    = 32'hE000_0000;
    dat[1]    = 32'hAAAA_0001;
    req_valid = 2'b11;
    #1;
    chk("lock_first_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b10;
    chk("lock_first_cmd",  cmd_data,    32'hE000_0000);
    chk("lock_first_grant", grant_id,   2'd0);
    chk("lock_set",        lock_active, LOCK_EN);
    repeat (BUSY_LEN) step();
    #1;
`ifdef CMD_ARB_RUN_LOCK_EN
    chk("lock_blocks_req1", req_ready, 2'b00);
    repeat (3) step();
    chk("lock_idle_busy", busy,        1'b0);
    chk("lock_held",      lock_active, 1'b1);
    dat[0]    = 32'h0000_0000;
    req_valid = 2'b11;
    #1;
    chk("lock_owner_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b10;
    chk("lock_owner_grant", grant_id,    2'd0);
    chk("lock_cleared",     lock_active, 1'b0);
    repeat (BUSY_LEN) step();
    #1;
    chk("lock_after_ready", req_ready, 2'b10);
    step();
    chk("lock_after_grant", grant_id, 2'd1);
    chk("lock_after_cmd",   cmd_data, 32'hAAAA_0001);
`else
    chk("nolock_ready", req_ready, 2'b10);
    step();
    chk("nolock_grant", grant_id,    2'd1);
    chk("nolock_cmd",   cmd_data,    32'hAAAA_0001);
    chk("nolock_flag",  lock_active, 1'b0);
`endif
    req_valid = '0;
    repeat (BUSY_LEN) step();

    // Randomized run against the transaction model
    begin
      logic [NR-1:0] pend;
      do_reset();
      pend = '0;
      for (int c = 0; c < 600; c++) begin
        int          w;
        logic [NR-1:0] exp_rdy;
        chk("rnd_cmd",   cmd_data,    m_cmd);
        chk("rnd_latch", latch_data,  (m_age >= 1 && m_age <= P));
        chk("rnd_busy",  busy,        (m_age < BUSY_LEN));
        chk("rnd_grant", grant_id,    32'(m_grant));
        chk("rnd_lock",  lock_active, m_lock);
        for (int i = 0; i < NR; i++) begin
          if (!pend[i] && $urandom_range(0, 9) < 4) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(0, 3) == 0) r[31:29] = 3'b111;
            dat[i]  = r;
            pend[i] = 1'b1;
          end else if (pend[i] && $urandom_range(0, 19) == 0) begin
            pend[i] = 1'b0;
          end
        end
        req_valid = pend;
        #1;
        w = (m_age >= BUSY_LEN) ? model_pick(req_valid) : -1;
        exp_rdy = (w >= 0) ? NR'(1 << w) : '0;
        chk("rnd_ready", req_ready, exp_rdy);
        if (w >= 0) begin
          m_cmd   = dat[w];
          m_grant = w;
          m_ptr   = w;
          m_age   = 0;
          if (LOCK_EN) begin
            if (dat[w][31:29] == 3'b111) begin
              m_lock  = 1'b1;
              m_owner = w;
            end else if (m_lock && w == m_owner) begin
              m_lock = 1'b0;
            end
          end
          pend[w] = 1'b0;
        end else if (m_age < BUSY_LEN) begin
          m_age++;
        end
        @(posedge clock);
        #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_arbiter.md
# cmd_arbiter

Shares the 32-bit command port of the system controller between several command sources (e.g. Wishbone host, logic-analyser loader, GPIO loader). Each source offers a command with a valid/ready handshake. The arbiter grants one command at a time in round-robin order and presents it on `cmd_data`. It then generates a clean `latch_data` pulse, with setup time and a recovery gap, so the controller's edge detector sees exactly one rising edge per command.

## Interface
- `NUM_REQ`, default 2: number of requesters (2..4).
- `PULSE_CYCLES`, default 2: cycles `latch_data` is held high (≥1).
- `GAP_CYCLES`, default 2: cycles `latch_data` is held low after the pulse, before the next grant (≥1).
- `clock` in 1: system clock; all logic is on the rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `req_valid` in NUM_REQ: requester i offers a command.
- `req_data` in 32·NUM_REQ: command of requester i, in bits [32i+31:32i].
- `req_ready` out NUM_REQ: one-hot accept. A transfer occurs on the edge where `req_valid[i] & req_ready[i]`.
- `cmd_data` out 32: registered command to the controller.
- `latch_data` out 1: registered latch strobe to the controller.
- `grant_id` out 2: index of the last accepted requester.
- `busy` out 1: high in any state other than IDLE.
- `lock_active` out 1: run-lock held (see Configuration).

## Operation
- FSM states: IDLE, SETUP, PULSE, GAP. Encodings live in the package.
- **IDLE**
  - `req_ready` is combinational and is high only for the round-robin winner among the asserted `req_valid` bits.
  - On a transfer: `cmd_data` ← winner's data; `grant_id` ← winner; round-robin pointer ← winner; go to SETUP.
- **SETUP**: one cycle; `cmd_data` is stable and `latch_data` is 0. Go to PULSE.
- **PULSE**: `latch_data` = 1 for PULSE_CYCLES cycles. A down-counter is loaded on entry. Go to GAP.
- **GAP**: `latch_data` = 0 for GAP_CYCLES cycles, then go to IDLE.
- `cmd_data` holds its value until the next transfer; it is never cleared between commands.
- Round-robin rule: search starts at pointer+1 modulo NUM_REQ.
- `req_ready` is 0 in every state except IDLE. Requesters hold `req_valid` and data until accepted.
- Width: the counter is clog2(max(PULSE_CYCLES, GAP_CYCLES)+1) bits. No other arithmetic.

## Timing
- Reset values: `cmd_data`=0, `latch_data`=0, `grant_id`=0, `busy`=0, `lock_active`=0, `req_ready`=0, state=IDLE, pointer=NUM_REQ-1 (so requester 0 wins first).
- Transfer at edge T:
  - SETUP occupies T..T+1.
  - `latch_data` rises at T+1.
  - `latch_data` falls at T+1+PULSE_CYCLES.
  - IDLE re-entered at T+1+PULSE_CYCLES+GAP_CYCLES.
- Throughput: one command per 2+PULSE_CYCLES+GAP_CYCLES cycles, including the IDLE accept cycle.
- Simultaneous valids: exactly one is accepted. The losers stay pending and are served in rotation, so none waits more than NUM_REQ-1 grants.
- A `req_valid` that drops before acceptance is legal; nothing is captured.
- Reset mid-operation: `latch_data` drops immediately (asynchronous). The in-flight command is discarded, `cmd_data` clears, and the pointer and lock reset.

## Configuration
- `CMD_ARB_RUN_LOCK_EN` defined:
  - Lock set: accepting a command with bits[31:30]=2'b11 and bit[29]=1 (run start) sets the lock to the accepting requester and raises `lock_active` at the same edge.
  - While locked, only the lock owner can be granted.
  - Lock release: any accepted command from the owner that is not a run start clears the lock.
- `CMD_ARB_RUN_LOCK_EN` undefined: pure round-robin, and `lock_active` is tied to 0.

## Structure
- Package `cmd_arb_pkg` contains:
  - the FSM state constants;
  - `CMD_SECTION_RUN` = 2'b11;
  - field positions: section [31:30], run-start bit 29.
- Sub-module `rr_pick`: combinational round-robin one-hot picker.
  - Inputs: request vector, pointer, optional lock mask.
  - Output: one-hot grant.

## Test plan
- Single request:
  - Stimulus: req 0 presents 32'h0001_00AA, with PULSE_CYCLES=2 and GAP_CYCLES=2.
  - Response: `cmd_data`=32'h0001_00AA one cycle before `latch_data` rises; `latch_data` high exactly 2 cycles; `busy` for 5 cycles.
- Contention:
  - Stimulus: req 0 and req 1 both held valid with distinct data.
  - Response: grants alternate 0,1,0,1; `grant_id` follows; exactly one `req_ready` bit high at a time.
- Back-to-back:
  - Stimulus: req 1 keeps `req_valid` high across 3 commands.
  - Response: 3 separate latch pulses, each preceded by ≥2 low cycles, with `cmd_data` updating only in SETUP.
- Reset mid-operation:
  - Stimulus: `reset_n` asserted during PULSE.
  - Response: `latch_data`, `cmd_data` and `busy` are 0 immediately; after release, req 0 has first priority.
- Run-lock (`CMD_ARB_RUN_LOCK_EN` defined):
  - Stimulus: req 0 sends 32'hE000_0000 while req 1 is pending.
  - Response: `lock_active`=1 and req 1 is blocked. Req 0 then sends 32'h0000_0000: the lock clears and req 1 is granted next.
- Run-lock (`CMD_ARB_RUN_LOCK_EN` undefined):
  - Stimulus: the same sequence.
  - Response: req 1 is granted immediately after req 0's first command.
